// File: rtl/crc32_pkg.sv
// ============================================================================
// Module : crc32_pkg
// Brief  : Shared FSM encoding and Ethernet CRC32 constants for the FCS inserter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package crc32_pkg;

   typedef enum logic [1:0] {
      PAYLOAD = 2'd0,
      PAD     = 2'd1,
      FCS     = 2'd2
   } crc_state_e;

   localparam logic [31:0] c_CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] c_CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] c_CRC32_XOROUT  = 32'hFFFF_FFFF;
   localparam int          c_MIN_FRAME_LEN = 60;

endpackage : crc32_pkg

`default_nettype wire

// File: rtl/lfsr.sv
// ============================================================================
// Module : lfsr
// Brief  : Combinational multi-bit LFSR step (Galois or Fibonacci, optional
//          bit-reversed operation), used here as a parallel CRC engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr #(
   parameter int                    LFSR_WIDTH        = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 32'h04C1_1DB7,
   parameter string                 LFSR_CONFIG       = "GALOIS",
   parameter int                    LFSR_FEED_FORWARD = 0,
   parameter int                    REVERSE           = 0,
   parameter int                    DATA_WIDTH        = 8
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [LFSR_WIDTH-1:0] state_in,
   output logic [LFSR_WIDTH-1:0] state_out
);

   function automatic logic [LFSR_WIDTH-1:0] f_bit_reverse(input logic [LFSR_WIDTH-1:0] v);
      logic [LFSR_WIDTH-1:0] r;
      r = '0;
      for (int j = 0; j < LFSR_WIDTH; j++) begin
         r[j] = v[LFSR_WIDTH-1-j];
      end
      return r;
   endfunction

   localparam logic [LFSR_WIDTH-1:0] c_POLY_REV = f_bit_reverse(LFSR_POLY);
   localparam bit                    c_FF       = (LFSR_FEED_FORWARD != 0);
   localparam bit                    c_REV      = (REVERSE != 0);

   // Reversed mode consumes data LSB first and shifts toward bit 0.
   if (LFSR_CONFIG == "GALOIS") begin : g_galois
      always_comb begin
         logic [LFSR_WIDTH-1:0] st;
         logic                  fb;
         st = state_in;
         fb = 1'b0;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (c_REV) begin
               fb = data_in[i] ^ (c_FF ? 1'b0 : st[0]);
               st = st >> 1;
               if (fb) st = st ^ c_POLY_REV;
            end else begin
               fb = data_in[DATA_WIDTH-1-i] ^ (c_FF ? 1'b0 : st[LFSR_WIDTH-1]);
               st = st << 1;
               if (fb) st = st ^ LFSR_POLY;
            end
         end
         state_out = st;
      end
   end else begin : g_fibonacci
      always_comb begin
         logic [LFSR_WIDTH-1:0] st;
         logic                  fb;
         st = state_in;
         fb = 1'b0;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (c_REV) begin
               fb = data_in[i] ^ (c_FF ? 1'b0 : ^(st & c_POLY_REV));
               st = {fb, st[LFSR_WIDTH-1:1]};
            end else begin
               fb = data_in[DATA_WIDTH-1-i] ^ (c_FF ? 1'b0 : ^(st & LFSR_POLY));
               st = {st[LFSR_WIDTH-2:0], fb};
            end
         end
         state_out = st;
      end
   end

endmodule : lfsr

`default_nettype wire

// File: rtl/axis_crc32_insert.sv
// ============================================================================
// Module : axis_crc32_insert
// Brief  : AXI-Stream byte pipe that appends the Ethernet FCS to each frame;
//          minimum-length zero padding when AXIS_CRC32_INSERT_PAD_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_crc32_insert
   import crc32_pkg::*;
#(
   parameter int MIN_FRAME_LEN = c_MIN_FRAME_LEN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast
);

   crc_state_e  state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] count_q, count_d;
   logic [1:0]  fcs_idx_q, fcs_idx_d;
   logic [7:0]  m_tdata_q, m_tdata_d;
   logic        m_tvalid_q, m_tvalid_d;
   logic        m_tlast_q, m_tlast_d;

   logic        w_out_ready;
   logic        w_s_fire;
   logic [15:0] w_count_inc;
   logic [7:0]  w_crc_byte;
   logic [31:0] w_crc_next;
   logic [31:0] w_fcs_word;
   logic [7:0]  w_fcs_byte;

   assign w_out_ready   = !m_tvalid_q || m_axis_tready;
   assign s_axis_tready = !rst && (state_q == PAYLOAD) && w_out_ready;
   assign w_s_fire      = s_axis_tvalid && s_axis_tready;
   assign w_count_inc   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
   assign w_fcs_word    = crc_q ^ c_CRC32_XOROUT;
   assign w_fcs_byte    = w_fcs_word[{fcs_idx_q, 3'b000} +: 8];

`ifdef AXIS_CRC32_INSERT_PAD_EN
   logic w_pad_needed;
   assign w_pad_needed = (32'(w_count_inc) < 32'(MIN_FRAME_LEN));
   assign w_crc_byte   = (state_q == PAD) ? 8'h00 : s_axis_tdata;
`else
   assign w_crc_byte   = s_axis_tdata;
   // Minimum length only matters to the padding path, absent in this build.
   if (MIN_FRAME_LEN > 16'hFFFF) begin : g_min_len_unused
   end
`endif

   lfsr #(
      .LFSR_WIDTH        (32),
      .LFSR_POLY         (c_CRC32_POLY),
      .LFSR_CONFIG       ("GALOIS"),
      .LFSR_FEED_FORWARD (0),
      .REVERSE           (1),
      .DATA_WIDTH        (8)
   ) u_crc_lfsr (
      .data_in   (w_crc_byte),
      .state_in  (crc_q),
      .state_out (w_crc_next)
   );

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      count_d    = count_q;
      fcs_idx_d  = fcs_idx_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;

      // A consumed output beat frees the register unless refilled below.
      if (w_out_ready) begin
         m_tvalid_d = 1'b0;
         m_tlast_d  = 1'b0;
      end

      case (state_q)
         PAYLOAD: begin
            if (w_s_fire) begin
               m_tdata_d  = s_axis_tdata;
               m_tvalid_d = 1'b1;
               crc_d      = w_crc_next;
               count_d    = w_count_inc;
               if (s_axis_tlast) begin
                  fcs_idx_d = 2'd0;
                  state_d   = FCS;
`ifdef AXIS_CRC32_INSERT_PAD_EN
                  if (w_pad_needed) state_d = PAD;
`endif
               end
            end
         end
`ifdef AXIS_CRC32_INSERT_PAD_EN
         PAD: begin
            if (w_out_ready) begin
               m_tdata_d  = 8'h00;
               m_tvalid_d = 1'b1;
               crc_d      = w_crc_next;
               count_d    = w_count_inc;
               if (!w_pad_needed) state_d = FCS;
            end
         end
`endif
         FCS: begin
            if (w_out_ready) begin
               m_tdata_d  = w_fcs_byte;
               m_tvalid_d = 1'b1;
               m_tlast_d  = (fcs_idx_q == 2'd3);
               fcs_idx_d  = fcs_idx_q + 2'd1;
               if (fcs_idx_q == 2'd3) begin
                  state_d = PAYLOAD;
                  crc_d   = c_CRC32_INIT;
                  count_d = 16'd0;
               end
            end
         end
         default: state_d = PAYLOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= PAYLOAD;
         crc_q      <= c_CRC32_INIT;
         count_q    <= 16'd0;
         fcs_idx_q  <= 2'd0;
         m_tdata_q  <= 8'h00;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         count_q    <= count_d;
         fcs_idx_q  <= fcs_idx_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;

endmodule : axis_crc32_insert

`default_nettype wire

// File: tb/tb_axis_crc32_insert.sv
// ============================================================================
// Module : tb_axis_crc32_insert
// Brief  : Scoreboard bench for axis_crc32_insert with a byte-level CRC32 model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_crc32_insert;

   localparam int c_MIN_LEN = 60;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic       s_tlast = 1'b0;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready = 1'b1;
   logic       m_tlast;

   int    total = 0;
   int    bad = 0;
   int    rdy_mode = 0;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   axis_crc32_insert #(.MIN_FRAME_LEN(c_MIN_LEN)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Bitwise reflected CRC32 straight from the Ethernet definition.
   function automatic logic [31:0] crc32_ref(input bq_t b);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c = c ^ {24'd0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic push_with_fcs(input bq_t f, input logic [31:0] fcs);
      foreach (f[i]) exp_q.push_back('{d: f[i], l: 1'b0});
      for (int k = 0; k < 4; k++) exp_q.push_back('{d: fcs[8*k +: 8], l: (k == 3)});
   endtask

   task automatic push_model(input bq_t p);
      bq_t f;
      f = p;
`ifdef AXIS_CRC32_INSERT_PAD_EN
      while (f.size() < c_MIN_LEN) f.push_back(8'h00);
`endif
      push_with_fcs(f, crc32_ref(f));
   endtask

   task automatic send_frame(input bq_t p, input bit gaps, input bit with_last, output int first_stall);
      int stall;
      first_stall = 0;
      for (int i = 0; i < p.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               s_tvalid = 1'b0;
               s_tdata  = 8'($urandom);
               s_tlast  = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         s_tvalid = 1'b1;
         s_tdata  = p[i];
         s_tlast  = with_last && (i == p.size() - 1);
         stall    = 0;
         forever begin
            @(negedge clk);
            if (s_tready) break;
            stall++;
            if (stall > 2000) begin
               total++; bad++;
               $display("FAIL in_handshake_timeout actual=stalled required=accept");
               break;
            end
         end
         if (i == 0) first_stall = stall;
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      beat_t      e;
      logic [7:0] pd;
      logic       pl;
      logic       stalled;
      stalled = 1'b0;
      pd = 8'h00;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("hold_valid", m_tvalid, 1);
               check("hold_data", m_tdata, pd);
               check("hold_last", m_tlast, pl);
            end
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_beat actual=%02h required=none", m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", m_tdata, e.d);
                  check("out_last", m_tlast, e.l);
               end
            end
            stalled = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
         end
      end
   end

   initial begin
      bq_t golden, p, q;
      int  st;
      golden = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

      #2;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_s_tready", s_tready, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_s_tready", s_tready, 1);
      @(posedge clk); #1;

      // Check-value frame, downstream always ready, then with toggling ready.
      for (int m = 0; m < 2; m++) begin
         rdy_mode = m;
`ifdef AXIS_CRC32_INSERT_PAD_EN
         push_model(golden);
`else
         push_with_fcs(golden, 32'hCBF4_3926);
`endif
         send_frame(golden, 1'b0, 1'b1, st);
         drain();
      end

      // Back-to-back frames with tvalid held: exactly 4 FCS beats of stall.
      rdy_mode = 0;
      p = {}; q = {};
      repeat (7) p.push_back(8'($urandom));
      repeat (5) q.push_back(8'($urandom));
      push_model(p);
      push_model(q);
      send_frame(p, 1'b0, 1'b1, st);
      send_frame(q, 1'b0, 1'b1, st);
`ifdef AXIS_CRC32_INSERT_PAD_EN
      check("b2b_stall", st, 4 + c_MIN_LEN - 7);
`else
      check("b2b_stall", st, 4);
`endif
      drain();

      // Reset after byte 5 of a frame, then a clean resend.
      p = golden[0:4];
      foreach (p[i]) exp_q.push_back('{d: p[i], l: 1'b0});
      send_frame(p, 1'b0, 1'b0, st);
      rst = 1'b1;
      #2;
      check("midrst_m_tvalid", m_tvalid, 0);
      check("midrst_s_tready", s_tready, 0);
      repeat (2) @(posedge clk);
      #1;
      check("midrst_hold_tvalid", m_tvalid, 0);
      exp_q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
`ifdef AXIS_CRC32_INSERT_PAD_EN
      push_model(golden);
`else
      push_with_fcs(golden, 32'hCBF4_3926);
`endif
      send_frame(golden, 1'b0, 1'b1, st);
      drain();

      // Single zero byte frame.
      p = '{8'h00};
`ifdef AXIS_CRC32_INSERT_PAD_EN
      push_model(p);
`else
      push_with_fcs(p, 32'hD202_EF8D);
`endif
      send_frame(p, 1'b0, 1'b1, st);
      drain();

      // Randomized frames, input gaps and downstream backpressure.
      for (int n = 0; n < 30; n++) begin
         rdy_mode = $urandom_range(0, 2);
         p = {};
`ifdef AXIS_CRC32_INSERT_PAD_EN
         repeat ($urandom_range(1, 80)) p.push_back(8'($urandom));
`else
         repeat ($urandom_range(1, 24)) p.push_back(8'($urandom));
`endif
         push_model(p);
         send_frame(p, 1'($urandom_range(0, 1)), 1'b1, st);
      end
      rdy_mode = 0;
      drain();
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_axis_crc32_insert

`default_nettype wire

// File: doc/axis_crc32_insert.md
AXIS_CRC32_INSERT -- requirements
Module: axis_crc32_insert

Interface
REQ-001 SHALL have parameter MIN_FRAME_LEN, default 60, meaning minimum pre-FCS byte count; it is used only when padding is compiled in.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 SHALL have port s_axis_tdata, input, 8 bits: payload byte.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: upstream byte valid.
REQ-006 SHALL have port s_axis_tready, output, 1 bit: block accepts the byte.
REQ-007 SHALL have port s_axis_tlast, input, 1 bit: last payload byte of frame.
REQ-008 SHALL have port m_axis_tdata, output, 8 bits: payload, pad or FCS byte.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: output byte valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the byte.
REQ-011 SHALL have port m_axis_tlast, output, 1 bit: asserted only on the final FCS byte.

Function
REQ-012 SHALL compute Ethernet CRC32: poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, one byte per transfer.
REQ-013 SHALL register all m_axis outputs; an accepted input byte appears on m_axis exactly 1 cycle later.
REQ-014 SHALL transfer a byte only when tvalid and tready are both high on the same edge, on both sides.
REQ-015 SHALL drive s_axis_tready = (state == PAYLOAD) and (m_axis_tvalid == 0 or m_axis_tready == 1).
REQ-016 SHALL implement the FSM states PAYLOAD, PAD and FCS, with reset state PAYLOAD.
REQ-017 SHALL, in PAYLOAD, update the CRC with each accepted byte; an accepted tlast moves to PAD if padding is needed, otherwise to FCS.
REQ-018 SHALL, in FCS, emit 4 bytes of ~crc, LSB byte first, then return to PAYLOAD with CRC = 0xFFFFFFFF and byte count = 0.
REQ-019 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-020 SHALL keep s_axis_tready low throughout PAD and FCS; a back-to-back frame is stalled until the last FCS byte is accepted.
REQ-021 SHALL count bytes per frame in a 16-bit counter that saturates at 0xFFFF.
REQ-022 SHALL treat a 1-byte frame (tlast on the first beat) as valid and emit 1 byte followed by 4 FCS bytes.
REQ-023 SHALL not be affected by s_axis_tdata or s_axis_tlast while s_axis_tvalid = 0.

Reset
REQ-024 SHALL, on rst high, immediately set m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0x00, state = PAYLOAD, CRC = 0xFFFFFFFF, count = 0.
REQ-025 SHALL discard any partial frame on reset mid-frame; the first frame after reset is computed from a fresh CRC.
REQ-026 SHALL drive s_axis_tready low while rst is high.

Configuration
REQ-027 SHALL, with macro AXIS_CRC32_INSERT_PAD_EN defined, enter PAD when the post-tlast count < MIN_FRAME_LEN, emit 0x00 bytes (included in the CRC) until count = MIN_FRAME_LEN, then enter FCS.
REQ-028 SHALL, without AXIS_CRC32_INSERT_PAD_EN, never enter PAD; the PAD state logic and MIN_FRAME_LEN compare are not synthesized.

Structure
REQ-029 SHALL place the FSM state enum, CRC32 poly/init/xorout constants and default MIN_FRAME_LEN in shared package crc32_pkg.
REQ-030 SHALL compute the next CRC with one instance of the existing lfsr module (LFSR_WIDTH 32, POLY 0x4C11DB7, GALOIS, FEED_FORWARD 0, REVERSE 1, DATA_WIDTH 8) as the only sub-module.
REQ-031 SHALL use a combinational CRC path only; the block remains fully pipelined at 1 byte per cycle in PAYLOAD.

Verification
REQ-032 SHALL verify: frame "123456789" (0x31..0x39), m_axis_tready = 1 -> 9 payload bytes, then 0x26 0x39 0xF4 0xCB, with tlast on 0xCB.
REQ-033 SHALL verify: same frame with m_axis_tready toggling 1/0 each cycle -> identical byte sequence, no drops or duplicates, outputs held while stalled.
REQ-034 SHALL verify: two back-to-back frames with tvalid held high -> s_axis_tready low for 4 FCS beats, and the second FCS is computed from init 0xFFFFFFFF.
REQ-035 SHALL verify: rst pulse after byte 5 of a frame, then resend "123456789" -> m_axis_tvalid = 0 during reset, then FCS = 0x26 0x39 0xF4 0xCB.
REQ-036 SHALL verify: with AXIS_CRC32_INSERT_PAD_EN, a 1-byte frame 0x00 -> 60 output bytes of 0x00 plus 4 FCS bytes equal to the CRC32 of 60 zero bytes.
REQ-037 SHALL verify: without AXIS_CRC32_INSERT_PAD_EN, a 1-byte frame 0x00 -> 1 byte, then 0x8D 0xEF 0x02 0xD2 (CRC32 0xD202EF8D).
